// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3
  } imm_sel_e;

  // Only the instruction fields the controller decodes; register indices
  // and immediates are consumed by the datapath directly.
  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } ir_fields_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b1100;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1110;

endpackage

// File: rtl/alu_control_decoder.sv
// Combinational map of opcode/funct3/funct7 to the ALU code and a legality flag.
module alu_control_decoder
  import control_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_code_o,
  output logic       legal_o
);

  logic [3:0] arith_code;

  // Shared funct3 map for register and immediate ALU ops; funct7[5] picks SRA.
  always_comb begin
    arith_code = ALU_ADD;
    unique case (funct3_i)
      3'b000: arith_code = ALU_ADD;
      3'b001: arith_code = ALU_SLL;
      3'b010: arith_code = ALU_SLT;
      3'b011: arith_code = ALU_SLTU;
      3'b100: arith_code = ALU_XOR;
      3'b101: arith_code = funct7_i[5] ? ALU_SRA : ALU_SRL;
      3'b110: arith_code = ALU_OR;
      3'b111: arith_code = ALU_AND;
      default: arith_code = ALU_ADD;
    endcase
  end

  // Per-opcode selection; ADDI never becomes SUB because only R-type overrides.
  always_comb begin
    alu_code_o = ALU_ADD;
    legal_o    = 1'b0;
    unique case (opcode_i)
      OP_R: begin
        alu_code_o = (funct3_i == 3'b000 && funct7_i[5]) ? ALU_SUB : arith_code;
        legal_o    = (funct7_i == 7'h00) || (funct7_i == 7'h20);
      end
      OP_IMM: begin
        alu_code_o = arith_code;
        legal_o    = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_AUIPC: begin
        alu_code_o = ALU_ADD;
        legal_o    = 1'b1;
      end
      OP_BRANCH: begin
        alu_code_o = ALU_SUB;
        legal_o    = (funct3_i == F3_BEQ) || (funct3_i == F3_BNE);
      end
      OP_LUI: begin
        alu_code_o = ALU_PASSB;
        legal_o    = 1'b1;
      end
      default: begin
        alu_code_o = ALU_ADD;
        legal_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control unit: accepts one instruction, sequences it through
// decode/execute/memory/write-back and drives the datapath strobes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a new instruction, IR loads on VALID
//   ST_DECODE | legality check, ILLEGAL pulse on unsupported encodings
//   ST_EXEC   | ALU op and operand selects driven; branches resolve here
//   ST_MEM    | load/store request held until MEM_READY or timeout
//   ST_WB     | register write strobe and retire
module control_multiciclo
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic        ZERO,
  input  logic        MEM_READY,
  output logic [3:0]  ALU_CONTROL,
  output logic        SRC_A,
  output logic        SRC_B,
  output logic [2:0]  IMM_SEL,
  output logic        REG_WRITE,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        PC_WRITE,
  output logic        DONE,
  output logic        ILLEGAL
);

  // Down-counter reload: the abort fires in the cycle the counter sits at zero.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  ir_fields_t       ir_q, ir_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [3:0]       alu_code;
  logic             legal;
  logic             is_load;
  logic             unused_operand_bits;

  assign unused_operand_bits = ^{INSTR[24:15], INSTR[11:7]};
  assign is_load = (ir_q.opcode == OP_LOAD);

  alu_control_decoder u_alu_dec (
    .opcode_i   (ir_q.opcode),
    .funct3_i   (ir_q.funct3),
    .funct7_i   (ir_q.funct7),
    .alu_code_o (alu_code),
    .legal_o    (legal)
  );

  // Next state and strobes; every output is forced low while RESET is high.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    tmr_d       = tmr_q;
    INSTR_READY = 1'b0;
    ALU_CONTROL = ALU_ADD;
    SRC_A       = 1'b0;
    SRC_B       = 1'b0;
    IMM_SEL     = IMM_I;
    REG_WRITE   = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    PC_WRITE    = 1'b0;
    DONE        = 1'b0;
    ILLEGAL     = 1'b0;
    if (!RESET) begin
      unique case (state_q)
        ST_IDLE: begin
          INSTR_READY = 1'b1;
          if (INSTR_VALID) begin
            ir_d    = '{funct7: INSTR[31:25], funct3: INSTR[14:12], opcode: INSTR[6:0]};
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!legal) begin
            ILLEGAL = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          ALU_CONTROL = alu_code;
          state_d     = ST_WB;
          unique case (ir_q.opcode)
            OP_R: ;
            OP_IMM: SRC_B = 1'b1;
            OP_LOAD: begin
              SRC_B   = 1'b1;
              state_d = ST_MEM;
              tmr_d   = CNT_LOAD;
            end
            OP_STORE: begin
              SRC_B   = 1'b1;
              IMM_SEL = IMM_S;
              state_d = ST_MEM;
              tmr_d   = CNT_LOAD;
            end
            OP_BRANCH: begin
              IMM_SEL  = IMM_B;
              PC_WRITE = (ir_q.funct3 == F3_BNE) ? !ZERO : ZERO;
              DONE     = 1'b1;
              state_d  = ST_IDLE;
            end
            OP_LUI: begin
              SRC_B   = 1'b1;
              IMM_SEL = IMM_U;
            end
            OP_AUIPC: begin
              SRC_A   = 1'b1;
              SRC_B   = 1'b1;
              IMM_SEL = IMM_U;
            end
            default: state_d = ST_IDLE;
          endcase
        end
        ST_MEM: begin
          MEM_READ  = is_load;
          MEM_WRITE = !is_load;
          if (MEM_READY) begin
            if (is_load) begin
              state_d = ST_WB;
            end else begin
              DONE    = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (MEM_TIMEOUT != 0 && tmr_q == '0) begin
            ILLEGAL = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q - CNT_W'(1);
          end
        end
        ST_WB: begin
          REG_WRITE = 1'b1;
          DONE      = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, instruction register and MEM timer with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench: two instances (no MEM timeout, and MEM_TIMEOUT = 3)
// driven by the same directed stimulus and checked every cycle against a
// cycle-count model of the instruction sequencing.
module tb_control_multiciclo;

  typedef struct packed {
    logic       ready;
    logic [3:0] alu;
    logic       src_a;
    logic       src_b;
    logic [2:0] imm;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       pcw;
    logic       done;
    logic       ill;
  } outs_t;

  // k: cycles into the instruction (1 decode, 2 exec, 3 mem, 4 write-back)
  typedef struct packed {
    logic        busy;
    logic [2:0]  k;
    logic [31:0] ir;
    logic [7:0]  mwait;
  } mdl_t;

  logic        CLK = 1'b0;
  logic        rst, valid, zero, mrdy;
  logic [31:0] instr;

  logic       rdy0, rdy1, sa0, sa1, sb0, sb1, rw0, rw1, mr0, mr1, mw0, mw1;
  logic       pcw0, pcw1, dn0, dn1, il0, il1;
  logic [3:0] alu0, alu1;
  logic [2:0] imm0, imm1;

  outs_t act [2];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 CLK = ~CLK;

  control_multiciclo u_dut (
    .CLK(CLK), .RESET(rst), .INSTR(instr), .INSTR_VALID(valid), .INSTR_READY(rdy0),
    .ZERO(zero), .MEM_READY(mrdy), .ALU_CONTROL(alu0), .SRC_A(sa0), .SRC_B(sb0),
    .IMM_SEL(imm0), .REG_WRITE(rw0), .MEM_READ(mr0), .MEM_WRITE(mw0),
    .PC_WRITE(pcw0), .DONE(dn0), .ILLEGAL(il0)
  );

  control_multiciclo #(.MEM_TIMEOUT(3)) u_dut_to (
    .CLK(CLK), .RESET(rst), .INSTR(instr), .INSTR_VALID(valid), .INSTR_READY(rdy1),
    .ZERO(zero), .MEM_READY(mrdy), .ALU_CONTROL(alu1), .SRC_A(sa1), .SRC_B(sb1),
    .IMM_SEL(imm1), .REG_WRITE(rw1), .MEM_READ(mr1), .MEM_WRITE(mw1),
    .PC_WRITE(pcw1), .DONE(dn1), .ILLEGAL(il1)
  );

  assign act[0] = {rdy0, alu0, sa0, sb0, imm0, rw0, mr0, mw0, pcw0, dn0, il0};
  assign act[1] = {rdy1, alu1, sa1, sb1, imm1, rw1, mr1, mw1, pcw1, dn1, il1};

  // What the instruction means: legality, class (0 alu/wb, 1 load, 2 store,
  // 3 branch) and the EXEC-cycle operand controls.
  function automatic void spec_info(input logic [31:0] ir, output bit legal,
                                    output int cls, output outs_t ex);
    logic [3:0] tbl [8];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    tbl = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b1001, 4'b1010, 4'b0001, 4'b0010};
    op = ir[6:0];
    f3 = ir[14:12];
    f7 = ir[31:25];
    ex = '0;
    legal = 1'b1;
    cls = 0;
    case (op)
      7'h33: begin
        legal  = (f7 == 7'h00) || (f7 == 7'h20);
        ex.alu = (f3 == 3'd0 && f7[5]) ? 4'b0111 :
                 (f3 == 3'd5 && f7[5]) ? 4'b1110 : tbl[f3];
      end
      7'h13: begin
        ex.src_b = 1'b1;
        ex.alu   = (f3 == 3'd5 && f7[5]) ? 4'b1110 : tbl[f3];
      end
      7'h03: begin ex.src_b = 1'b1; cls = 1; end
      7'h23: begin ex.src_b = 1'b1; ex.imm = 3'd1; cls = 2; end
      7'h63: begin ex.alu = 4'b0111; ex.imm = 3'd2; cls = 3; legal = (f3 < 3'd2); end
      7'h37: begin ex.alu = 4'b0110; ex.src_b = 1'b1; ex.imm = 3'd3; end
      7'h17: begin ex.src_a = 1'b1; ex.src_b = 1'b1; ex.imm = 3'd3; end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic void model_step(input mdl_t m, input int tmo, input logic r,
                                     input logic v, input logic z, input logic md,
                                     input logic [31:0] ins, output outs_t o,
                                     output mdl_t n);
    bit    legal;
    int    cls;
    outs_t ex;
    n = m;
    o = '0;
    if (r) begin
      n = '0;
      return;
    end
    if (!m.busy) begin
      o.ready = 1'b1;
      if (v) begin
        n.busy = 1'b1;
        n.k    = 3'd1;
        n.ir   = ins;
      end
      return;
    end
    spec_info(m.ir, legal, cls, ex);
    case (m.k)
      3'd1: begin
        if (!legal) begin o.ill = 1'b1; n.busy = 1'b0; end
        else n.k = 3'd2;
      end
      3'd2: begin
        o = ex;
        if (cls == 3) begin
          o.pcw  = m.ir[12] ? !z : z;
          o.done = 1'b1;
          n.busy = 1'b0;
        end else if (cls == 1 || cls == 2) begin
          n.k = 3'd3;
          n.mwait = '0;
        end else begin
          n.k = 3'd4;
        end
      end
      3'd3: begin
        o.mr = (cls == 1);
        o.mw = (cls == 2);
        if (md) begin
          if (cls == 1) n.k = 3'd4;
          else begin o.done = 1'b1; n.busy = 1'b0; end
        end else if (tmo > 0 && int'(m.mwait) + 1 == tmo) begin
          o.ill  = 1'b1;
          n.busy = 1'b0;
        end else begin
          n.mwait = m.mwait + 8'd1;
        end
      end
      default: begin
        o.rw   = 1'b1;
        o.done = 1'b1;
        n.busy = 1'b0;
      end
    endcase
  endfunction

  // Every-cycle comparison of both instances against the model.
  initial begin
    mdl_t  m [2];
    mdl_t  n [2];
    outs_t e;
    int    tmo [2];
    tmo = '{0, 3};
    m[0] = '0;
    m[1] = '0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        model_step(m[i], tmo[i], rst, valid, zero, mrdy, instr, e, n[i]);
        n_assert++;
        if (act[i] !== e) begin
          n_fail++;
          $display("FAIL model_cmp[inst%0d] t=%0t got %h want %h", i, $time, act[i], e);
        end
      end
      @(posedge CLK);
      m = n;
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_assert++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  // Present an instruction in IDLE; returns just after the accept edge (DECODE).
  task automatic send(input logic [31:0] ins, input logic z, input logic md);
    @(posedge CLK); #1;
    instr = ins; valid = 1'b1; zero = z; mrdy = md;
    @(negedge CLK);
    chk("accept_ready", 32'(act[0].ready), 1);
    @(posedge CLK); #1;
    valid = 1'b0;
  endtask

  logic [31:0] t_ins [15];
  logic [3:0]  t_alu [15];
  logic        t_sa  [15];
  logic        t_sb  [15];
  logic [2:0]  t_imm [15];

  initial begin
    int c_mr0, c_mr1, c_il1, c_rw1, c_rw0;
    t_ins = '{32'h40208033, 32'h4050D093, 32'h12345037, 32'h00001097, 32'h002080B3,
              32'h002090B3, 32'h0020A0B3, 32'h0020B0B3, 32'h0020C0B3, 32'h0020D0B3,
              32'h4020D0B3, 32'h0020E0B3, 32'h0020F0B3, 32'h40008093, 32'h0010D093};
    t_alu = '{4'b0111, 4'b1110, 4'b0110, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b1100,
              4'b1001, 4'b1010, 4'b1110, 4'b0001, 4'b0010, 4'b0000, 4'b1010};
    t_sa  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    t_sb  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    t_imm = '{3'd0, 3'd0, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
              3'd0, 3'd0, 3'd0};
    rst = 1'b1; valid = 1'b0; instr = '0; zero = 1'b0; mrdy = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset_outputs", 32'(act[0]), 0);
    chk("reset_ready", 32'(act[1].ready), 0);
    @(posedge CLK); #1 rst = 1'b0;
    @(negedge CLK);
    chk("idle_ready", 32'(act[0].ready), 1);

    // ALU / LUI / AUIPC: DECODE, EXEC, WB
    for (int i = 0; i < 15; i++) begin
      send(t_ins[i], 1'b0, 1'b0);
      @(negedge CLK);
      chk("alu_decode_ill", 32'(act[0].ill), 0);
      @(negedge CLK);
      chk("exec_alu", 32'(act[0].alu), 32'(t_alu[i]));
      chk("exec_src_a", 32'(act[0].src_a), 32'(t_sa[i]));
      chk("exec_src_b", 32'(act[0].src_b), 32'(t_sb[i]));
      chk("exec_imm", 32'(act[0].imm), 32'(t_imm[i]));
      @(negedge CLK);
      chk("wb_reg_write", 32'(act[0].rw), 1);
      chk("wb_done", 32'(act[0].done), 1);
    end

    // Branches: {instr, zero, expected PC_WRITE}
    for (int i = 0; i < 4; i++) begin
      logic [31:0] bi;
      logic        bz, bp;
      bi = (i < 2) ? 32'h00208463 : 32'h00209463;
      bz = (i == 0 || i == 3);
      bp = (i == 0 || i == 2);
      send(bi, bz, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      chk("branch_pc_write", 32'(act[0].pcw), 32'(bp));
      chk("branch_done", 32'(act[0].done), 1);
      chk("branch_imm", 32'(act[0].imm), 2);
      @(negedge CLK);
      chk("branch_back_idle", 32'(act[0].ready), 1);
    end

    // Load with MEM_READY low for five MEM cycles
    send(32'h0000A083, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("load_exec_srcb", 32'(act[0].src_b), 1);
    c_mr0 = 0; c_mr1 = 0; c_il1 = 0; c_rw1 = 0; c_rw0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        @(posedge CLK); #1 mrdy = 1'b1;
      end
      @(negedge CLK);
      c_mr0 += int'(act[0].mr);
      c_rw0 += int'(act[0].rw);
      c_mr1 += int'(act[1].mr);
      c_il1 += int'(act[1].ill);
      c_rw1 += int'(act[1].rw);
    end
    @(posedge CLK); #1 mrdy = 1'b0;
    @(negedge CLK);
    c_rw1 += int'(act[1].rw);
    chk("load_mem_read_cycles", 32'(c_mr0), 6);
    chk("load_no_early_wb", 32'(c_rw0), 0);
    chk("load_wb_reg_write", 32'(act[0].rw), 1);
    chk("timeout_mem_read_cycles", 32'(c_mr1), 3);
    chk("timeout_illegal", 32'(c_il1), 1);
    chk("timeout_no_reg_write", 32'(c_rw1), 0);

    // Illegal encodings
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ii;
      ii = (i == 0) ? 32'h0000007F : (i == 1) ? 32'h02208033 : 32'h0020C463;
      send(ii, 1'b0, 1'b0);
      @(negedge CLK);
      chk("illegal_pulse", 32'(act[0].ill), 1);
      chk("illegal_no_done", 32'(act[0].done), 0);
      @(negedge CLK);
      chk("illegal_ready_after", 32'(act[0].ready), 1);
    end

    // Store with MEM_READY already high: completes in one MEM cycle
    send(32'h0020A023, 1'b0, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    chk("store_exec_imm", 32'(act[0].imm), 1);
    @(negedge CLK);
    chk("store_mem_write", 32'(act[0].mw), 1);
    chk("store_done", 32'(act[0].done), 1);
    @(posedge CLK); #1 mrdy = 1'b0;
    @(negedge CLK);
    chk("store_back_idle", 32'(act[0].ready), 1);

    // Store aborted by reset in MEM
    send(32'h0020A023, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("store_wait_mem_write", 32'(act[0].mw), 1);
    @(posedge CLK); #1 rst = 1'b1;
    @(negedge CLK);
    chk("reset_mid_mem_outputs", 32'(act[0]), 0);
    chk("reset_mid_mem_to_outputs", 32'(act[1]), 0);
    @(posedge CLK); #1 rst = 1'b0;
    @(negedge CLK);
    chk("after_reset_ready", 32'(act[0].ready), 1);
    chk("after_reset_no_done", 32'(act[0].done), 0);

    // INSTR_VALID during EXEC/WB must not be consumed
    send(32'h002080B3, 1'b0, 1'b0);
    @(negedge CLK);
    @(posedge CLK); #1 instr = 32'h0000007F; valid = 1'b1;
    @(negedge CLK);
    chk("busy_exec_ready", 32'(act[0].ready), 0);
    chk("busy_exec_alu", 32'(act[0].alu), 0);
    @(posedge CLK); #1 valid = 1'b0;
    @(negedge CLK);
    chk("busy_wb_ready", 32'(act[0].ready), 0);
    chk("busy_wb_reg_write", 32'(act[0].rw), 1);
    @(posedge CLK); #1 valid = 1'b1;
    @(negedge CLK);
    chk("idle_again_ready", 32'(act[0].ready), 1);
    @(posedge CLK); #1 valid = 1'b0;
    @(negedge CLK);
    chk("late_accept_illegal", 32'(act[0].ill), 1);
    @(negedge CLK);
    chk("final_ready", 32'(act[0].ready), 1);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
